// File: rtl/seg7_pkg.sv
// Shared constants and types for the four-digit seven-segment scanner.
// Glyphs are active-low, with the MSB of each entry driving segment a and the LSB driving segment g.
package seg7_pkg;

  localparam int NUM_DIGITS = 4;

  localparam logic [6:0] SEG_BLANK = 7'b111_1111;

  localparam logic [6:0] GLYPH_TABLE [16] = '{
    7'b000_0001,  // 0
    7'b100_1111,  // 1
    7'b001_0010,  // 2
    7'b000_0110,  // 3
    7'b100_1100,  // 4
    7'b010_0100,  // 5
    7'b010_0000,  // 6
    7'b000_1111,  // 7
    7'b000_0000,  // 8
    7'b000_0100,  // 9
    7'b000_1000,  // A
    7'b110_0000,  // b
    7'b011_0001,  // C
    7'b100_0010,  // d
    7'b011_0000,  // E
    7'b011_1000   // F
  };

  // One complete frame's worth of display content.
  typedef struct packed {
    logic [4*NUM_DIGITS-1:0] value;
    logic [NUM_DIGITS-1:0]   blank;
    logic [NUM_DIGITS-1:0]   dp;
  } frame_t;

  localparam frame_t FRAME_RESET = '{value: '0, blank: '1, dp: '0};

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low seven-segment glyph decoder.
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] glyph
);

  assign glyph = GLYPH_TABLE[nibble];

endmodule

// File: rtl/seg7_scan_mux.sv
// Time-multiplexed four-digit seven-segment driver with tear-free, frame-aligned updates.
// A load is staged in a pending register and is only applied to the display at a frame boundary.
module seg7_scan_mux
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV = 50_000,
  parameter int DIV_W       = 16
) (
  input  logic                    clk,
  input  logic                    arst,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  output logic                    update_pending,
  output logic                    frame_done,
  output logic [0:6]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an
);

  localparam logic [DIV_W-1:0] CNT_LAST = DIV_W'(REFRESH_DIV - 1);

  logic [DIV_W-1:0] cnt_q;
  logic [1:0]       idx_q;
  logic [1:0]       idx_nxt;
  logic             tick;
  logic             boundary;
  frame_t           pend_q;
  frame_t           disp_q;
  frame_t           disp_nxt;
  frame_t           in_frame;
  logic [3:0]       nibble_nxt;
  logic [6:0]       glyph_nxt;

  assign tick     = (cnt_q == CNT_LAST);
  assign boundary = tick && (idx_q == 2'd3);
  assign idx_nxt  = idx_q + 2'd1;
  assign in_frame = '{value: value_in, blank: blank_in, dp: dp_in};

  // A load landing on the boundary bypasses the pending stage entirely.
  always_comb begin
    disp_nxt = disp_q;
    if (boundary) begin
      if (load)                disp_nxt = in_frame;
      else if (update_pending) disp_nxt = pend_q;
    end
  end

  // Decode from the upcoming digit and display so outputs switch together with idx.
  assign nibble_nxt = disp_nxt.value[{idx_nxt, 2'b00} +: 4];

  hex_to_seg7 u_decode (
    .nibble (nibble_nxt),
    .glyph  (glyph_nxt)
  );

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      cnt_q          <= '0;
      idx_q          <= 2'd3;
      pend_q         <= FRAME_RESET;
      disp_q         <= FRAME_RESET;
      update_pending <= 1'b0;
      frame_done     <= 1'b0;
      an             <= '1;
      seg            <= SEG_BLANK;
      dp             <= 1'b1;
    end else begin
      cnt_q      <= tick ? '0 : cnt_q + DIV_W'(1);
      frame_done <= boundary;
      disp_q     <= disp_nxt;

      if (boundary) begin
        update_pending <= 1'b0;
      end else if (load) begin
        pend_q         <= in_frame;
        update_pending <= 1'b1;
      end

      if (tick) begin
        idx_q <= idx_nxt;
        an    <= ~(NUM_DIGITS'(1) << idx_nxt);
        if (disp_nxt.blank[idx_nxt]) begin
          seg <= SEG_BLANK;
          dp  <= 1'b1;
        end else begin
          seg <= glyph_nxt;
          dp  <= ~disp_nxt.dp[idx_nxt];
        end
      end
    end
  end

endmodule

// File: doc/seg7_scan_mux.md
SEG7_SCAN_MUX -- requirements
Module: seg7_scan_mux

Interface
REQ-001 Parameter REFRESH_DIV, default 50_000, SHALL set the number of clk cycles each digit is lit (1 kHz digit rate at 50 MHz).
REQ-002 Parameter DIV_W, default 16, SHALL set the prescaler width and SHALL satisfy 2**DIV_W >= REFRESH_DIV.
REQ-003 Port clk, input, 1, SHALL be the system clock; all state SHALL change on its rising edge.
REQ-004 Port arst, input, 1, SHALL be the asynchronous, active-high reset.
REQ-005 Port value_in, input, 16, SHALL carry four hex nibbles: digit 0 = [3:0] … digit 3 = [15:12].
REQ-006 Port blank_in, input, 4, SHALL carry per-digit blank flags, where 1 means the digit stays dark.
REQ-007 Port dp_in, input, 4, SHALL carry per-digit decimal-point enables, where 1 means the point is lit.
REQ-008 Port load, input, 1, SHALL be a single-cycle strobe that captures value_in, blank_in and dp_in.
REQ-009 Port update_pending, output, 1, SHALL be high while a captured update has not yet reached the display.
REQ-010 Port frame_done, output, 1, SHALL pulse for one cycle at each frame boundary.
REQ-011 Port seg[0:6], output, 7, SHALL drive segments a..g, active-low, with seg[0]=a.
REQ-012 Port dp, output, 1, SHALL drive the decimal point, active-low.
REQ-013 Port an[3:0], output, 4, SHALL drive the digit anodes, active-low, with an[i] selecting digit i.

Function
REQ-014 The prescaler SHALL count 0..REFRESH_DIV-1 and wrap; tick SHALL be asserted in the cycle where count==REFRESH_DIV-1.
REQ-015 Digit index idx (2 bits) SHALL advance 3->0->1->2->3 on each tick; frame boundary = tick with idx==3.
REQ-016 On load, the block SHALL capture the inputs into a pending register and set update_pending on the next edge.
REQ-016a A later load while update_pending is high SHALL overwrite the pending register (latest wins).
REQ-017 At a frame boundary with update_pending=1, the pending register SHALL copy into the display register and update_pending SHALL clear.
REQ-018 If load coincides with a frame boundary, value_in/blank_in/dp_in SHALL go directly to the display register and update_pending SHALL end low.
REQ-019 The display register SHALL change only at frame boundaries, so no frame mixes old and new values (no tearing).
REQ-020 an, seg and dp SHALL be registered and SHALL update on the same edge idx advances, from the new idx.
REQ-020a an SHALL equal ~(1<<idx); seg SHALL equal glyph(display nibble[idx]); dp SHALL equal ~display_dp[idx].
REQ-021 When display_blank[idx]=1, seg SHALL be 7'b111_1111 and dp SHALL be 1, while an still selects the digit.
REQ-022 frame_done SHALL be registered and high for exactly the cycle after each frame boundary edge.
REQ-023 Glyphs SHALL be standard hex: 0=0000001, 1=1001111, 8=0000000, A=0001000, F=0111000 (bit order a..g).

Reset
REQ-024 During and after arst, prescaler=0 and idx=3.
REQ-025 During and after arst, display value, pending value and dp registers=0, and display and pending blank=4'b1111.
REQ-026 During and after arst, update_pending=0, frame_done=0, an=4'b1111, seg=7'b111_1111 and dp=1.
REQ-027 An arst asserted mid-frame SHALL abort the frame and discard any pending update.
REQ-028 The first tick after reset release SHALL be a frame boundary, so a load before it appears on digit 0 at that tick.

Structure
REQ-029 Package seg7_pkg SHALL hold NUM_DIGITS=4, the 16-entry active-low glyph table, and SEG_BLANK=7'b111_1111.
REQ-030 A combinational sub-module hex_to_seg7 (4-bit in, 7-bit out) SHALL perform glyph decoding; all sequential logic SHALL stay in seg7_scan_mux.

Verification (REFRESH_DIV=4)
REQ-031 Reset release, no load -> an steps 1110,1101,1011,0111 every 4 cycles, seg=1111111 throughout, frame_done pulses every 16 cycles.
REQ-032 Load value_in=16'h8A10, blank_in=0, dp_in=4'b0100 before the first tick -> digit0 seg=0000001, digit1 seg=1001111, digit2 seg=0001000 with dp=0, digit3 seg=0000000.
REQ-033 Load 16'h1111 mid-frame -> update_pending=1 and the current frame is unchanged; the new value shows from the next digit-0 onward and update_pending clears at the boundary.
REQ-034 Two loads (16'h2222 then 16'hFFFF) in the same frame -> only FFFF is displayed (seg=0111000 on all digits).
REQ-035 Load coincident with the boundary tick -> the value shows on digit 0 at that edge and update_pending stays 0.
REQ-036 arst pulse mid-frame with a load pending -> an=1111, seg=1111111, update_pending=0; after release, the display stays blank until a new load.
